// File: rtl/dmem_bus_master_if.sv
// Pipeline request/response and external data-memory bus signals (DDT excluded: it is a top-level inout).
// master = the bus initiator, slave = the pipeline/memory environment driving it.
interface dmem_bus_master_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 req_valid;
  logic                 req_write;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic [BIT_WIDTH-1:0] req_addr;
  logic [BIT_WIDTH-1:0] req_wdata;
  logic                 req_ready;
  logic                 rsp_valid;
  logic [BIT_WIDTH-1:0] rsp_rdata;
  logic                 rsp_fault_align;
  logic                 rsp_timeout;
  logic                 busy;
  logic [BIT_WIDTH-1:0] DAD;
  logic                 MREQ;
  logic                 WRITE;
  logic [1:0]           SIZE;
  logic                 ACKD_n;

  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ACKD_n,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault_align, rsp_timeout, busy,
           DAD, MREQ, WRITE, SIZE
  );

  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ACKD_n,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault_align, rsp_timeout, busy,
           DAD, MREQ, WRITE, SIZE
  );
endinterface

// File: rtl/dmem_bus_master.sv
// Load/store to external data-memory bus initiator: one request -> one acked bus cycle, with
// alignment faults (no bus activity), bounded-wait timeout, and sign/zero-extended load return.
module dmem_bus_master #(
  parameter int BIT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_bus_master_if.master    bus,
  inout  wire  [BIT_WIDTH-1:0] DDT
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  localparam int             CW     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  TO_LIM = CW'(TIMEOUT_CYCLES);
  localparam bit             TO_EN  = (TIMEOUT_CYCLES != 0);

  state_t               r_state;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_mreq;
  logic                 r_write;
  logic [1:0]           r_size;
  logic [BIT_WIDTH-1:0] r_dad;
  logic [BIT_WIDTH-1:0] r_wdata;
  logic                 r_uns;
  logic [CW-1:0]        r_cnt;
  logic                 r_rsp_vld;
  logic [BIT_WIDTH-1:0] r_rdata;
  logic                 r_fault;
  logic                 r_tmo;

  logic                 w_accept;
  logic                 w_misalign;
  logic                 w_ack;
  logic [CW-1:0]        w_cnt_nxt;
  logic [1:0]           w_bus_size;
  logic [BIT_WIDTH-1:0] w_wdata_j;
  logic [BIT_WIDTH-1:0] w_load_ext;

  assign w_accept   = bus.req_valid & r_ready;
  assign w_misalign = (bus.req_size == 2'b11)
                    | ((bus.req_size == 2'b01) & bus.req_addr[0])
                    | ((bus.req_size == 2'b10) & (|bus.req_addr[1:0]));
  assign w_ack      = ~bus.ACKD_n;
  assign w_cnt_nxt  = r_cnt + 1'b1;

  always_comb begin
    w_bus_size = 2'b00;
    w_wdata_j  = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        w_bus_size = 2'b10;
        w_wdata_j  = {{(BIT_WIDTH-8){1'b0}}, bus.req_wdata[7:0]};
      end
      2'b01: begin
        w_bus_size = 2'b01;
        w_wdata_j  = {{(BIT_WIDTH-16){1'b0}}, bus.req_wdata[15:0]};
      end
      default: begin
        w_bus_size = 2'b00;
        w_wdata_j  = bus.req_wdata;
      end
    endcase
  end

  // r_size holds the bus encoding (10 byte, 01 half, 00 word)
  always_comb begin
    w_load_ext = DDT;
    case (r_size)
      2'b10:   w_load_ext = {{(BIT_WIDTH-8){~r_uns & DDT[7]}}, DDT[7:0]};
      2'b01:   w_load_ext = {{(BIT_WIDTH-16){~r_uns & DDT[15]}}, DDT[15:0]};
      default: w_load_ext = DDT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_mreq    <= 1'b0;
      r_write   <= 1'b0;
      r_size    <= 2'b00;
      r_dad     <= '0;
      r_wdata   <= '0;
      r_uns     <= 1'b0;
      r_cnt     <= '0;
      r_rsp_vld <= 1'b0;
      r_rdata   <= '0;
      r_fault   <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_rsp_vld <= 1'b0;
      r_rdata   <= '0;
      r_fault   <= 1'b0;
      r_tmo     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (w_misalign) begin
              r_state   <= S_RESP;
              r_rsp_vld <= 1'b1;
              r_fault   <= 1'b1;
            end else begin
              r_state <= S_BUS;
              r_mreq  <= 1'b1;
              r_dad   <= bus.req_addr;
              r_size  <= w_bus_size;
              r_write <= bus.req_write;
              r_wdata <= w_wdata_j;
              r_uns   <= bus.req_unsigned;
              r_cnt   <= '0;
            end
          end
        end
        S_BUS: begin
          // ack takes priority over a timeout expiring on the same edge
          if (w_ack) begin
            r_state   <= S_RESP;
            r_mreq    <= 1'b0;
            r_rsp_vld <= 1'b1;
            r_rdata   <= r_write ? '0 : w_load_ext;
            r_cnt     <= '0;
          end else if (TO_EN && (w_cnt_nxt == TO_LIM)) begin
            r_state   <= S_RESP;
            r_mreq    <= 1'b0;
            r_rsp_vld <= 1'b1;
            r_tmo     <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_mreq  <= 1'b0;
        end
      endcase
    end
  end

  assign DDT = (r_mreq & r_write) ? r_wdata : {BIT_WIDTH{1'bz}};

  assign bus.req_ready       = r_ready;
  assign bus.busy            = r_busy;
  assign bus.rsp_valid       = r_rsp_vld;
  assign bus.rsp_rdata       = r_rdata;
  assign bus.rsp_fault_align = r_fault;
  assign bus.rsp_timeout     = r_tmo;
  assign bus.DAD             = r_dad;
  assign bus.MREQ            = r_mreq;
  assign bus.WRITE           = r_write;
  assign bus.SIZE            = r_size;

endmodule

// File: tb/tb_dmem_bus_master.sv
// Randomized + directed bench for dmem_bus_master against a transaction-level reference model.
// The memory side parks DDT at a known pattern whenever the master is not writing.
module tb_dmem_bus_master;

  localparam int          W    = 32;
  localparam int          TO   = 4;
  localparam logic [31:0] PARK = 32'h5A5A_C3C3;

  logic        clk;
  logic        rst;
  logic [31:0] mem_dat;
  wire  [31:0] ddt;
  int          n_cmp;
  int          n_err;

  dmem_bus_master_if #(.BIT_WIDTH(W)) bus ();

  dmem_bus_master #(.BIT_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .DDT (ddt)
  );

  assign ddt = (bus.MREQ && bus.WRITE) ? 32'hzzzz_zzzz : (bus.MREQ ? mem_dat : PARK);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input bit uns, input logic [31:0] m);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = m % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = m % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = m;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_store(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return d % 256;
    if (sz == 2'd1) return d % 65536;
    return d;
  endfunction

  function automatic logic [31:0] exp_bus_size(input logic [1:0] sz);
    if (sz == 2'd0) return 32'd2;
    if (sz == 2'd1) return 32'd1;
    return 32'd0;
  endfunction

  // waits = number of un-acked BUS edges before the memory acks
  task automatic run_txn(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] md, input int waits, input bit stale);
    bit fault;
    bit tmo;
    int last_k;
    fault  = (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0);
    tmo    = (waits >= TO);
    last_k = tmo ? TO : waits + 1;

    @(negedge clk);
    chk("idle_ready", bus.req_ready, 1);
    chk("idle_busy", bus.busy, 0);
    chk("idle_mreq", bus.MREQ, 0);
    chk("idle_rsp", bus.rsp_valid, 0);
    if (stale) bus.ACKD_n = 1'b0;
    mem_dat          = md;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;

    @(negedge clk);
    bus.req_valid = 1'b0;
    if (fault) begin
      chk("flt_rsp", bus.rsp_valid, 1);
      chk("flt_align", bus.rsp_fault_align, 1);
      chk("flt_tmo", bus.rsp_timeout, 0);
      chk("flt_rdata", bus.rsp_rdata, 0);
      chk("flt_mreq", bus.MREQ, 0);
      chk("flt_busy", bus.busy, 1);
      chk("flt_ready", bus.req_ready, 0);
    end else begin
      for (int k = 1; k <= last_k; k++) begin
        chk("bus_mreq", bus.MREQ, 1);
        chk("bus_rsp", bus.rsp_valid, 0);
        chk("bus_dad", bus.DAD, addr);
        chk("bus_size", bus.SIZE, exp_bus_size(sz));
        chk("bus_write", bus.WRITE, wr);
        chk("bus_busy", bus.busy, 1);
        chk("bus_ready", bus.req_ready, 0);
        chk("bus_ddt", ddt, wr ? exp_store(sz, wd) : md);
        bus.ACKD_n = (k == waits + 1) ? 1'b0 : 1'b1;
        @(negedge clk);
      end
      chk("rsp_valid", bus.rsp_valid, 1);
      chk("rsp_tmo", bus.rsp_timeout, tmo);
      chk("rsp_align", bus.rsp_fault_align, 0);
      chk("rsp_rdata", bus.rsp_rdata, (wr || tmo) ? 32'd0 : exp_load(sz, uns, md));
      chk("rsp_mreq", bus.MREQ, 0);
      chk("rsp_ddt", ddt, PARK);
      chk("rsp_busy", bus.busy, 1);
      chk("rsp_ready", bus.req_ready, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] addr;
    n_cmp            = 0;
    n_err            = 0;
    rst              = 1'b1;
    mem_dat          = 32'd0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;
    bus.ACKD_n       = 1'b1;

    @(negedge clk);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mreq", bus.MREQ, 0);
    chk("rst_write", bus.WRITE, 0);
    chk("rst_size", bus.SIZE, 0);
    chk("rst_dad", bus.DAD, 0);
    chk("rst_rsp", bus.rsp_valid, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_ddt", ddt, PARK);
    rst = 1'b0;

    // word load, single-edge ack
    run_txn(0, 2'd2, 0, 32'h0800_0010, 32'd0, 32'hDEAD_BEEF, 0, 0);
    // byte/half extension
    run_txn(0, 2'd0, 0, 32'h0800_0003, 32'd0, 32'h0000_80F0, 0, 0);
    run_txn(0, 2'd0, 1, 32'h0800_0001, 32'd0, 32'h0000_80F0, 1, 0);
    run_txn(0, 2'd1, 0, 32'h0800_0002, 32'd0, 32'h0000_80F0, 0, 0);
    run_txn(0, 2'd1, 1, 32'h0800_0006, 32'd0, 32'h0000_80F0, 2, 0);
    // stores, high addresses
    run_txn(1, 2'd0, 0, 32'hF000_0000, 32'h1234_56A5, 32'd0, 0, 0);
    run_txn(1, 2'd1, 0, 32'hFF00_0000, 32'h1234_56A5, 32'd0, 1, 0);
    run_txn(1, 2'd2, 0, 32'hFF00_0004, 32'h1234_56A5, 32'd0, 0, 0);
    // stale ack low at accept, three wait edges, ack on 4th edge (coincides with timeout)
    run_txn(0, 2'd2, 0, 32'h0800_0020, 32'd0, 32'hCAFE_F00D, 3, 1);
    // faults
    run_txn(0, 2'd1, 0, 32'h0800_0001, 32'd0, 32'd0, 0, 0);
    run_txn(0, 2'd3, 0, 32'h0800_0000, 32'd0, 32'd0, 0, 1);
    run_txn(1, 2'd2, 0, 32'h0800_0002, 32'hFFFF_FFFF, 32'd0, 0, 0);
    // timeout with ack stuck high
    run_txn(0, 2'd2, 0, 32'h0800_0040, 32'd0, 32'h1111_2222, 9, 0);
    run_txn(1, 2'd0, 0, 32'h0800_0041, 32'h0000_00AA, 32'd0, 5, 1);

    for (int i = 0; i < 60; i++) begin
      sz   = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      addr = $urandom();
      if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(exp_bus_size(2'd2) == 0 ? (sz == 2'd2 ? 3 : (sz == 2'd1 ? 1 : 0)) : 0));
      run_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr,
              $urandom(), $urandom(), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    // asynchronous reset in the middle of a store bus cycle
    @(negedge clk);
    bus.req_write    = 1'b1;
    bus.req_size     = 2'd2;
    bus.req_addr     = 32'h0800_0080;
    bus.req_wdata    = 32'h7654_3210;
    bus.ACKD_n       = 1'b1;
    bus.req_valid    = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mid_mreq", bus.MREQ, 1);
    chk("mid_ddt", ddt, 32'h7654_3210);
    #2 rst = 1'b1;
    #1;
    chk("arst_mreq", bus.MREQ, 0);
    chk("arst_ddt", ddt, PARK);
    chk("arst_rsp", bus.rsp_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_ready", bus.req_ready, 1);
    chk("arst_dad", bus.DAD, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("post_rst_rsp", bus.rsp_valid, 0);
      chk("post_rst_ready", bus.req_ready, 1);
      chk("post_rst_mreq", bus.MREQ, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
